// File: rtl/kf_weight_port_arbiter_if.sv
// Request, handshake and RAM-side signals of the synapse weight port arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the weight RAM.
interface kf_weight_port_arbiter_if #(
    parameter int ADDR_W  = 12,
    parameter int W_WIDTH = 8
);
    logic               core_rd_req;
    logic               core_rd_ready;
    logic [ADDR_W-1:0]  core_rd_addr;
    logic               core_rd_valid;
    logic [W_WIDTH-1:0] core_rd_data;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [W_WIDTH-1:0] cfg_wdata;
    logic               dream_valid;
    logic               dream_ready;
    logic [ADDR_W-1:0]  dream_addr;
    logic [W_WIDTH-1:0] dream_delta;
    logic               mem_en;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [W_WIDTH-1:0] mem_wdata;
    logic [W_WIDTH-1:0] mem_rdata;

    modport slave (
        input  core_rd_req, core_rd_addr, cfg_valid, cfg_addr, cfg_wdata,
               dream_valid, dream_addr, dream_delta, mem_rdata,
        output core_rd_ready, core_rd_valid, core_rd_data, cfg_ready, dream_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output core_rd_req, core_rd_addr, cfg_valid, cfg_addr, cfg_wdata,
               dream_valid, dream_addr, dream_delta, mem_rdata,
        input  core_rd_ready, core_rd_valid, core_rd_data, cfg_ready, dream_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/kf_weight_port_arbiter.sv
// Shares the single-port synapse weight RAM between core reads, host writes and
// saturating dream-engine read-modify-write updates, with starvation protection for dream.
//
//   state  | meaning
//   IDLE   | no RMW in flight; dream request may be accepted
//   RD     | waiting for a RAM slot to read the dream target
//   WAIT   | read data returning; compute clamped sum
//   WR     | waiting for a RAM slot to write the clamped result
module kf_weight_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int W_WIDTH    = 8,
    parameter int STARVE_MAX = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    kf_weight_port_arbiter_if.slave   bus,
    output logic                      rmw_busy,
    output logic [31:0]               upd_count,
    output logic [15:0]               sat_count
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} state_t;

    localparam logic [7:0] STARVE_LIM = STARVE_MAX[7:0];

    state_t             state, state_nxt;
    logic [7:0]         starve_cnt;
    logic [ADDR_W-1:0]  d_addr;
    logic [W_WIDTH-1:0] d_delta;
    logic [W_WIDTH-1:0] d_result;
    logic               d_sat;
    logic               rd_core_q;
    logic               dream_pend;
    logic               forced;
    logic               core_gnt;
    logic               cfg_gnt;
    logic               dream_gnt;
    logic [W_WIDTH:0]   sum;
    logic               sum_ovf;
    logic [W_WIDTH-1:0] sum_clamped;

    // Sign-extended add; overflow shows as disagreement between the two top bits.
    assign sum         = {bus.mem_rdata[W_WIDTH-1], bus.mem_rdata} + {d_delta[W_WIDTH-1], d_delta};
    assign sum_ovf     = sum[W_WIDTH] ^ sum[W_WIDTH-1];
    assign sum_clamped = !sum_ovf      ? sum[W_WIDTH-1:0] :
                         sum[W_WIDTH]  ? {1'b1, {(W_WIDTH-1){1'b0}}} :
                                         {1'b0, {(W_WIDTH-1){1'b1}}};

    assign dream_pend = (state == S_IDLE && bus.dream_valid) || state == S_RD || state == S_WR;
    assign forced     = dream_pend && (starve_cnt >= STARVE_LIM);

    always_comb begin
        state_nxt       = state;
        core_gnt        = 1'b0;
        cfg_gnt         = 1'b0;
        dream_gnt       = 1'b0;
        bus.dream_ready = 1'b0;
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        if (!rst) begin
            core_gnt = bus.core_rd_req && !forced;
            cfg_gnt  = bus.cfg_valid && state == S_IDLE && !bus.core_rd_req && !forced;
            case (state)
                S_IDLE: begin
                    bus.dream_ready = forced || (!bus.cfg_valid && !bus.core_rd_req);
                    if (bus.dream_valid && bus.dream_ready) begin
                        dream_gnt = 1'b1;
                        state_nxt = S_RD;
                    end
                end
                S_RD: if (forced || !bus.core_rd_req) begin
                    dream_gnt = 1'b1;
                    state_nxt = S_WAIT;
                end
                S_WAIT: state_nxt = S_WR;
                S_WR: if (forced || !bus.core_rd_req) begin
                    dream_gnt = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
            if (core_gnt) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.core_rd_addr;
            end else if (cfg_gnt) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.cfg_addr;
                bus.mem_wdata = bus.cfg_wdata;
            end else if (dream_gnt && state == S_RD) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = d_addr;
            end else if (dream_gnt && state == S_WR) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = d_addr;
                bus.mem_wdata = d_result;
            end
        end
    end

    assign bus.core_rd_ready = core_gnt;
    assign bus.cfg_ready     = cfg_gnt;
    // Owner tag: only core reads are flagged; a dream read always lands in WAIT.
    assign bus.core_rd_valid = rd_core_q && !rst;
    assign bus.core_rd_data  = bus.core_rd_valid ? bus.mem_rdata : '0;
    assign rmw_busy          = !rst && state != S_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            d_addr     <= '0;
            d_delta    <= '0;
            d_result   <= '0;
            d_sat      <= 1'b0;
            rd_core_q  <= 1'b0;
            upd_count  <= '0;
            sat_count  <= '0;
        end else begin
            state     <= state_nxt;
            rd_core_q <= core_gnt;
            if (dream_gnt)
                starve_cnt <= '0;
            else if (dream_pend && starve_cnt < STARVE_LIM)
                starve_cnt <= starve_cnt + 8'd1;
            if (state == S_IDLE && dream_gnt) begin
                d_addr  <= bus.dream_addr;
                d_delta <= bus.dream_delta;
            end
            if (state == S_WAIT) begin
                d_result <= sum_clamped;
                d_sat    <= sum_ovf;
            end
            if (state == S_WR && dream_gnt) begin
                upd_count <= upd_count + 32'd1;
                if (d_sat && sat_count != 16'hFFFF)
                    sat_count <= sat_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_kf_weight_port_arbiter.sv
// Scoreboard bench for kf_weight_port_arbiter: stimulus pushes expected RAM accesses and
// core read data; a negedge monitor pops and compares whenever the DUT presents them.
module tb_kf_weight_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rmw_busy;
    logic [31:0] upd_count;
    logic [15:0] sat_count;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    kf_weight_port_arbiter_if #(.ADDR_W(12), .W_WIDTH(8)) bus ();

    kf_weight_port_arbiter #(.ADDR_W(12), .W_WIDTH(8), .STARVE_MAX(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .rmw_busy  (rmw_busy),
        .upd_count (upd_count),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ram [4096];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram[bus.mem_addr];
    end

    typedef struct { logic we; logic [11:0] addr; logic [7:0] wdata; int cyc; } mem_exp_t;
    typedef struct { logic [7:0] data; int cyc; } rd_exp_t;
    mem_exp_t exp_mem[$];
    rd_exp_t  exp_rd[$];
    mem_exp_t em;
    rd_exp_t  er;

    always @(negedge clk) begin
        if (bus.mem_en) begin
            checks++;
            if (exp_mem.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected cyc=%0d got we=%0b addr=%0d wdata=%0h, required no access",
                         cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata);
            end else begin
                em = exp_mem.pop_front();
                if (bus.mem_we !== em.we || bus.mem_addr !== em.addr ||
                    (em.we && bus.mem_wdata !== em.wdata) || (em.cyc >= 0 && em.cyc != cyc)) begin
                    errors++;
                    $display("FAIL mem_access got we=%0b addr=%0d wdata=%0h cyc=%0d, required we=%0b addr=%0d wdata=%0h cyc=%0d",
                             bus.mem_we, bus.mem_addr, bus.mem_wdata, cyc, em.we, em.addr, em.wdata, em.cyc);
                end
            end
        end
        if (bus.core_rd_valid) begin
            checks++;
            if (exp_rd.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected cyc=%0d got data=%0h, required no valid", cyc, bus.core_rd_data);
            end else begin
                er = exp_rd.pop_front();
                if (bus.core_rd_data !== er.data || (er.cyc >= 0 && er.cyc != cyc)) begin
                    errors++;
                    $display("FAIL core_rd got data=%0h cyc=%0d, required data=%0h cyc=%0d",
                             bus.core_rd_data, cyc, er.data, er.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s got no handshake, required one within 100 cycles", name);
    endtask

    // Handshake tasks are entered just after a posedge and return just after a posedge.
    task automatic core_hs(input logic [11:0] a, output int t);
        bus.core_rd_addr = a;
        bus.core_rd_req  = 1'b1;
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.core_rd_ready) begin t = cyc; break; end
            @(posedge clk); #1;
        end
        if (t < 0) timeout("core_hs");
        @(posedge clk); #1;
        bus.core_rd_req = 1'b0;
    endtask

    task automatic cfg_hs(input logic [11:0] a, input logic [7:0] d, output int waits);
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        bus.cfg_valid = 1'b1;
        waits = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.cfg_ready) begin waits = i; break; end
            @(posedge clk); #1;
        end
        if (waits < 0) timeout("cfg_hs");
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic dream_hs(input logic [11:0] a, input logic [7:0] d, output int t);
        bus.dream_addr  = a;
        bus.dream_delta = d;
        bus.dream_valid = 1'b1;
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.dream_ready) begin t = cyc; break; end
            @(posedge clk); #1;
        end
        if (t < 0) timeout("dream_hs");
        @(posedge clk); #1;
        bus.dream_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!rmw_busy) begin done = 1'b1; break; end
        end
        if (!done) timeout("wait_idle");
        @(posedge clk); #1;
    endtask

    task automatic cfg_load(input logic [11:0] a, input logic [7:0] d);
        int w;
        exp_mem.push_back('{1'b1, a, d, -1});
        cfg_hs(a, d, w);
    endtask

    task automatic core_load(input logic [11:0] a, input logic [7:0] d);
        int t;
        exp_mem.push_back('{1'b0, a, 8'h00, -1});
        exp_rd.push_back('{d, -1});
        core_hs(a, t);
    endtask

    // Accept at T: read at T+1, clamped write at T+3.
    task automatic dream_rmw(input logic [11:0] a, input logic [7:0] d, input logic [7:0] res,
                             output int t);
        dream_hs(a, d, t);
        if (t >= 0) begin
            exp_mem.push_back('{1'b0, a, 8'h00, t + 1});
            exp_mem.push_back('{1'b1, a, res, t + 3});
        end
        wait_idle();
    endtask

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog got no end of test, required finish within 5000 cycles");
        $fatal(1);
    end

    initial begin
        int t, t2, w, s;
        bit frc;
        bus.core_rd_req = 1'b1; bus.core_rd_addr = '0;
        bus.cfg_valid = 1'b1;   bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.dream_valid = 1'b1; bus.dream_addr = '0; bus.dream_delta = '0;

        // reset with every requester asserted: everything must stay quiet
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_core_rd_ready", {31'b0, bus.core_rd_ready}, 0);
        check("rst_cfg_ready", {31'b0, bus.cfg_ready}, 0);
        check("rst_dream_ready", {31'b0, bus.dream_ready}, 0);
        check("rst_mem_en", {31'b0, bus.mem_en}, 0);
        check("rst_rmw_busy", {31'b0, rmw_busy}, 0);
        check("rst_upd_count", upd_count, 0);
        check("rst_sat_count", {16'b0, sat_count}, 0);
        @(posedge clk); #1;
        bus.core_rd_req = 1'b0; bus.cfg_valid = 1'b0; bus.dream_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // dream only, exact timing
        cfg_load(12'd5, 8'd10);
        dream_hs(12'd5, 8'd3, t);
        exp_mem.push_back('{1'b0, 12'd5, 8'h00, t + 1});
        exp_mem.push_back('{1'b1, 12'd5, 8'd13, t + 3});
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_busy_T3", {31'b0, rmw_busy}, 1);
        check("t1_dream_ready_T3", {31'b0, bus.dream_ready}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_busy_T4", {31'b0, rmw_busy}, 0);
        check("t1_dream_ready_T4", {31'b0, bus.dream_ready}, 1);
        check("t1_upd_count", upd_count, 1);
        check("t1_sat_count", {16'b0, sat_count}, 0);
        @(posedge clk); #1;
        core_load(12'd5, 8'd13);

        // saturation at both rails, then a non-saturating negative step
        cfg_load(12'd7, 8'd120);
        cfg_load(12'd8, 8'h88);
        dream_rmw(12'd7, 8'd20, 8'h7F, t);
        check("t2_sat_pos", {16'b0, sat_count}, 1);
        dream_rmw(12'd8, 8'hEC, 8'h80, t);
        dream_rmw(12'd8, 8'd5, 8'h85, t);
        check("t2_upd_count", upd_count, 4);
        check("t2_sat_count", {16'b0, sat_count}, 2);

        // three-way priority: core at P, cfg at P+1, dream accepted at P+2
        cfg_load(12'd21, 8'h10);
        s = cyc;
        exp_mem.push_back('{1'b0, 12'd5, 8'h00, s});
        exp_rd.push_back('{8'd13, s + 1});
        exp_mem.push_back('{1'b1, 12'd20, 8'h55, s + 1});
        fork
            core_hs(12'd5, t2);
            cfg_hs(12'd20, 8'h55, w);
            dream_rmw(12'd21, 8'd1, 8'h11, t);
            begin
                @(negedge clk);
                check("t3_core_ready", {31'b0, bus.core_rd_ready}, 1);
                check("t3_cfg_ready", {31'b0, bus.cfg_ready}, 0);
                check("t3_dream_ready", {31'b0, bus.dream_ready}, 0);
            end
        join
        check("t3_dream_accept_cyc", t - s, 2);
        core_load(12'd20, 8'h55);

        // atomicity: cfg to the RMW address is held off until IDLE
        cfg_load(12'd9, 8'd50);
        dream_hs(12'd9, 8'd1, t);
        exp_mem.push_back('{1'b0, 12'd9, 8'h00, t + 1});
        exp_mem.push_back('{1'b1, 12'd9, 8'd51, t + 3});
        exp_mem.push_back('{1'b1, 12'd9, 8'h22, t + 4});
        cfg_hs(12'd9, 8'h22, w);
        check("t4_cfg_wait_cycles", w, 3);
        core_load(12'd9, 8'h22);
        check("t4_upd_count", upd_count, 6);

        // starvation: core held on, dream forced every 16th cycle of each access
        cfg_load(12'd30, 8'd0);
        s = cyc;
        for (int k = 0; k <= 48; k++) begin
            if (k == 31) exp_mem.push_back('{1'b0, 12'd30, 8'h00, s + k});
            else if (k == 48) exp_mem.push_back('{1'b1, 12'd30, 8'd2, s + k});
            else if (k != 15) begin
                exp_mem.push_back('{1'b0, 12'd5, 8'h00, s + k});
                exp_rd.push_back('{8'd13, s + k + 1});
            end
        end
        bus.core_rd_addr = 12'd5; bus.core_rd_req = 1'b1;
        bus.dream_addr = 12'd30; bus.dream_delta = 8'd2; bus.dream_valid = 1'b1;
        for (int k = 0; k <= 48; k++) begin
            frc = (k == 15 || k == 31 || k == 48);
            @(negedge clk);
            check($sformatf("t5_core_ready_k%0d", k), {31'b0, bus.core_rd_ready}, {31'b0, !frc});
            check($sformatf("t5_dream_ready_k%0d", k), {31'b0, bus.dream_ready}, (k == 15) ? 1 : 0);
            @(posedge clk); #1;
            if (k == 15) bus.dream_valid = 1'b0;
            if (k == 48) bus.core_rd_req = 1'b0;
        end
        wait_idle();
        core_load(12'd30, 8'd2);
        check("t5_upd_count", upd_count, 7);
        check("t5_sat_count", {16'b0, sat_count}, 2);

        // reset during WAIT aborts the RMW without a write
        cfg_load(12'd40, 8'h30);
        dream_hs(12'd40, 8'd5, t);
        exp_mem.push_back('{1'b0, 12'd40, 8'h00, t + 1});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus.cfg_addr = 12'd40; bus.cfg_wdata = 8'h77; bus.cfg_valid = 1'b1;
        bus.core_rd_addr = 12'd40; bus.core_rd_req = 1'b1;
        @(negedge clk);
        check("t6_mem_en", {31'b0, bus.mem_en}, 0);
        check("t6_core_ready", {31'b0, bus.core_rd_ready}, 0);
        check("t6_cfg_ready", {31'b0, bus.cfg_ready}, 0);
        check("t6_rmw_busy", {31'b0, rmw_busy}, 0);
        check("t6_upd_count", upd_count, 0);
        check("t6_sat_count", {16'b0, sat_count}, 0);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0; bus.core_rd_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("t6_dream_ready_after", {31'b0, bus.dream_ready}, 1);
        repeat (4) @(posedge clk);
        #1;
        core_load(12'd40, 8'h30);

        repeat (3) @(posedge clk);
        #1;
        check("mem_queue_drained", exp_mem.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
